mem_loader: RTL and testbench

Byte-stream firmware loader that acts as an initiator on the native memory bus (mem_valid/mem_ready). It assembles little-endian 32-bit words from an incoming byte stream and writes them into memory starting at a base address. While loading it holds the CPU core off via `hold_core`. It is the write-side counterpart to the core's byte output port.

---
 rtl/mem_loader_pkg.sv | 13 +
 rtl/mem_loader_if.sv | 20 ++
 rtl/mem_loader_word_asm.sv | 27 ++
 rtl/mem_loader.sv | 103 ++++++++++
 tb/tb_mem_loader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared states and constants for the byte-stream firmware loader
package mem_loader_pkg;
    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_e;
    localparam logic [3:0] WSTRB_ALL = 4'b1111;
    localparam int LEN_BYTES = 4;
endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream input and native memory bus seen by the loader
interface mem_loader_if;
    logic [7:0]  in_byte;
    logic        in_byte_en;
    logic        in_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (
        input  in_byte, in_byte_en, mem_ready, mem_rdata,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
    modport slave (
        output in_byte, in_byte_en, mem_ready, mem_rdata,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_loader_word_asm.sv
// mem_loader_word_asm: gathers four LSB-first bytes; word/word_valid present the completed word in the cycle its last byte arrives
module mem_loader_word_asm
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  cnt;
    logic [23:0] sh;
    assign word       = {byte_in, sh};
    assign word_valid = byte_en && cnt == 2'(LEN_BYTES - 1);
    // shift each accepted byte in from the top so the first byte lands in bits 7:0
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
            sh  <= '0;
        end else if (byte_en) begin
            cnt <= cnt + 2'd1;
            sh  <= {byte_in, sh[23:8]};
        end
    end
endmodule

// File: rtl/mem_loader.sv
// mem_loader: byte-stream firmware loader writing words over the native memory bus; read-back check under MEM_LOADER_VERIFY_EN
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_SIZE  = 4096
) (
    input  logic         clk,
    input  logic         reset,
    mem_loader_if.master bus,
    output logic         hold_core,
    output logic         done,
    output logic         error,
    output logic [31:0]  err_addr
);
    state_e      state;
    logic [31:0] n;
    logic [31:0] i;
    logic [31:0] i_nxt;
    logic [31:0] word;
    logic        word_valid;
    assign i_nxt        = i + 32'd1;
    assign bus.in_ready = !reset && (state == S_LEN || state == S_DATA);
    mem_loader_word_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (!bus.in_ready),
        .byte_en    (bus.in_byte_en && bus.in_ready),
        .byte_in    (bus.in_byte),
        .word       (word),
        .word_valid (word_valid)
    );
    // load sequencer: length, data words, bus writes (and read-back), terminal states
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_LEN;
            n             <= '0;
            i             <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            hold_core     <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            err_addr      <= '0;
        end else begin
            case (state)
                S_LEN: if (word_valid) begin
                    n <= word;
                    i <= '0;
                    if (word > MEM_SIZE) begin
                        state    <= S_ERROR;
                        error    <= 1'b1;
                        err_addr <= word;
                    end else if (word == '0) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        hold_core <= 1'b0;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: if (word_valid) begin
                    state         <= S_WRITE;
                    bus.mem_valid <= 1'b1;
                    bus.mem_addr  <= BASE_ADDR + {i[29:0], 2'b00};
                    bus.mem_wdata <= word;
                    bus.mem_wstrb <= WSTRB_ALL;
                end
                S_WRITE: if (bus.mem_ready) begin
                    bus.mem_valid <= 1'b0;
                    i             <= i_nxt;
`ifdef MEM_LOADER_VERIFY_EN
                    state <= S_VERIFY;
`else
                    state     <= (i_nxt == n) ? S_DONE : S_DATA;
                    done      <= i_nxt == n;
                    hold_core <= i_nxt != n;
`endif
                end
`ifdef MEM_LOADER_VERIFY_EN
                S_VERIFY: if (!bus.mem_valid) begin
                    bus.mem_valid <= 1'b1;
                    bus.mem_wstrb <= '0;
                end else if (bus.mem_ready) begin
                    bus.mem_valid <= 1'b0;
                    if (bus.mem_rdata != bus.mem_wdata) begin
                        state    <= S_ERROR;
                        error    <= 1'b1;
                        err_addr <= bus.mem_addr;
                    end else begin
                        state     <= (i == n) ? S_DONE : S_DATA;
                        done      <= i == n;
                        hold_core <= i != n;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed checks of the firmware loader against hand-computed bus traffic
module tb_mem_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        hold_core;
    logic        done;
    logic        error;
    logic [31:0] err_addr;
    int          vecs = 0;
    int          errs = 0;
    int          nw = 0;
    int          vcyc = 0;
    int          n0;
    int          v0;
    logic [31:0] wa [$];
    logic [31:0] wd [$];
    logic [31:0] mem [16];
    logic [31:0] bad = 32'hFFFF_FFFF;

    mem_loader_if bus ();

    mem_loader #(.BASE_ADDR(32'h0000_0000), .MEM_SIZE(4096)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .hold_core (hold_core),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    always_comb bus.mem_rdata = (bus.mem_addr == bad) ? 32'h0 : mem[bus.mem_addr[5:2]];

    always @(negedge clk) begin
        #1;
        if (!reset && bus.mem_valid) vcyc++;
        if (!reset && bus.mem_valid && bus.mem_ready && bus.mem_wstrb == 4'hF) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
            mem[bus.mem_addr[5:2]] = bus.mem_wdata;
            nw++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        bus.in_byte    = b;
        bus.in_byte_en = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            ok = bus.in_ready;
            @(negedge clk);
        end
        if (!ok) begin
            vecs++;
            errs++;
            $error("FAIL send_timeout: byte %h not accepted, observed in_ready 0 expected 1", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
        bus.in_byte_en = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 30 && !(done || error); k++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.in_byte_en = 1'b0;
        bus.mem_ready  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_byte    = 8'h00;
        bus.in_byte_en = 1'b0;
        bus.mem_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_hold_core", 32'(hold_core), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_addr", err_addr, 32'h0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        send_word(32'd2);
        send_word(32'h1234_5678);
        chk("w0_valid", 32'(bus.mem_valid), 32'd1);
        chk("w0_addr", bus.mem_addr, 32'h0);
        chk("w0_wdata", bus.mem_wdata, 32'h1234_5678);
        chk("w0_wstrb", 32'(bus.mem_wstrb), 32'hF);
        chk("w0_in_ready_low", 32'(bus.in_ready), 32'd0);
`ifndef MEM_LOADER_VERIFY_EN
        @(negedge clk);
        chk("w0_in_ready_back", 32'(bus.in_ready), 32'd1);
        chk("w0_valid_dropped", 32'(bus.mem_valid), 32'd0);
        chk("w0_count", 32'(nw), 32'd1);
`endif
        send_word(32'hDEAD_BEEF);
        chk("w1_valid", 32'(bus.mem_valid), 32'd1);
        chk("w1_addr", bus.mem_addr, 32'h4);
        chk("w1_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("w1_done_not_yet", 32'(done), 32'd0);
`ifndef MEM_LOADER_VERIFY_EN
        @(negedge clk);
        chk("w1_done_next_cycle", 32'(done), 32'd1);
`endif
        wait_done();
        chk("load2_done", 32'(done), 32'd1);
        chk("load2_hold_core", 32'(hold_core), 32'd0);
        chk("load2_error", 32'(error), 32'd0);
        chk("load2_in_ready", 32'(bus.in_ready), 32'd0);
        chk("load2_writes", 32'(nw), 32'd2);
        chk("load2_addr0", wa[0], 32'h0);
        chk("load2_data0", wd[0], 32'h1234_5678);
        chk("load2_addr1", wa[1], 32'h4);
        chk("load2_data1", wd[1], 32'hDEAD_BEEF);

        do_reset();
        v0 = vcyc;
        send_word(32'd0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_hold_core", 32'(hold_core), 32'd0);
        chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("len0_no_valid", 32'(vcyc - v0), 32'd0);

        do_reset();
        n0 = nw;
        v0 = vcyc;
        send_word(32'h0000_1001);
        chk("lenbig_error", 32'(error), 32'd1);
        chk("lenbig_err_addr", err_addr, 32'h0000_1001);
        chk("lenbig_done", 32'(done), 32'd0);
        chk("lenbig_hold_core", 32'(hold_core), 32'd1);
        chk("lenbig_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("lenbig_no_writes", 32'(nw - n0), 32'd0);
        chk("lenbig_no_valid", 32'(vcyc - v0), 32'd0);

        do_reset();
        send_word(32'h0000_1000);
        chk("lenmax_error", 32'(error), 32'd0);
        chk("lenmax_in_ready", 32'(bus.in_ready), 32'd1);

        do_reset();
        send_word(32'd1);
        bus.mem_ready = 1'b0;
        n0 = nw;
        send_word(32'h4433_2211);
        for (int c = 0; c < 4; c++) begin
            chk("ws_valid", 32'(bus.mem_valid), 32'd1);
            chk("ws_addr", bus.mem_addr, 32'h0);
            chk("ws_wdata", bus.mem_wdata, 32'h4433_2211);
            chk("ws_in_ready", 32'(bus.in_ready), 32'd0);
            if (c == 3) bus.mem_ready = 1'b1;
            @(negedge clk);
        end
        chk("ws_valid_dropped", 32'(bus.mem_valid), 32'd0);
        chk("ws_one_write", 32'(nw - n0), 32'd1);
        wait_done();
        chk("ws_done", 32'(done), 32'd1);

        do_reset();
        bus.mem_ready = 1'b0;
        send_word(32'd2);
        send_word(32'hDDCC_BBAA);
        chk("rstw_valid", 32'(bus.mem_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_valid_cleared", 32'(bus.mem_valid), 32'd0);
        chk("rstw_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rstw_hold_core", 32'(hold_core), 32'd1);
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n0 = nw;
        send_word(32'd1);
        send_word(32'h0123_4567);
        wait_done();
        chk("rstw_done", 32'(done), 32'd1);
        chk("rstw_writes", 32'(nw - n0), 32'd1);
        chk("rstw_addr", wa[n0], 32'h0);
        chk("rstw_data", wd[n0], 32'h0123_4567);

`ifdef MEM_LOADER_VERIFY_EN
        do_reset();
        bad = 32'h8;
        send_word(32'd3);
        send_word(32'h0000_0000);
        send_word(32'h0000_0001);
        send_word(32'hCAFE_F00D);
        wait_done();
        chk("vfy_error", 32'(error), 32'd1);
        chk("vfy_err_addr", err_addr, 32'h8);
        chk("vfy_done", 32'(done), 32'd0);
        chk("vfy_hold_core", 32'(hold_core), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
